// File: rtl/fc_seq_ctrl.sv
// rtl/fc_seq_ctrl.sv - frame sequencer between rx FIFO, FC layer and UART transmitter
//
// Purpose:
//   Waits until the rx FIFO holds a full input vector. It then streams that
//   vector byte by byte into the FC layer and waits for the FC result pulse.
//   The results are captured and serialised to the UART transmitter. The
//   block counts completed frames.
//
// Optional feature (macro FC_SEQ_TIMEOUT_EN):
//   Adds a WAIT_FC watchdog. If no fc_out_valid arrives within TIMEOUT_CYC
//   cycles, the frame is dropped, the block returns to IDLE and timeout_err
//   pulses for one cycle. Without the macro, WAIT_FC waits indefinitely and
//   the timeout_err port does not exist.
//
// Ports:
//   clk, rst_n     - single rising-edge clock, asynchronous active-low reset
//   fifo_count     - rx FIFO occupancy
//   fifo_empty     - rx FIFO empty flag
//   fifo_rd_en     - rx FIFO read strobe (data valid on fifo_dout next cycle)
//   fifo_dout      - rx FIFO read data
//   fc_in_dat      - byte to FC layer (fifo_dout passed through)
//   fc_in_valid    - fc_in_dat qualifier (fifo_rd_en delayed one cycle)
//   fc_out_dat     - flattened FC results, neuron k at [k*DATA_W +: DATA_W]
//   fc_out_valid   - one-cycle FC result pulse
//   tx_data        - byte offered to UART
//   tx_data_valid  - tx_data offered
//   tx_data_ready  - UART accepts when valid & ready
//   busy           - high in any state except IDLE
//   timeout_err    - one-cycle watchdog pulse (FC_SEQ_TIMEOUT_EN only)
//   frame_cnt      - completed frames, wraps 0xFFFF -> 0

module fc_seq_ctrl #(
    parameter int DIM_INPUT   = 96,
    parameter int DIM_OUTPUT  = 8,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CNT_W-1:0]             fifo_count,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [DATA_W-1:0]            fifo_dout,
    output logic [DATA_W-1:0]            fc_in_dat,
    output logic                         fc_in_valid,
    input  logic [DATA_W*DIM_OUTPUT-1:0] fc_out_dat,
    input  logic                         fc_out_valid,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_data_valid,
    input  logic                         tx_data_ready,
    output logic                         busy,
`ifdef FC_SEQ_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output logic [15:0]                  frame_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PUSH    = 2'd1;
    localparam logic [1:0] S_WAIT_FC = 2'd2;
    localparam logic [1:0] S_POP     = 2'd3;

    // push_cnt must be able to hold DIM_INPUT itself (the "all read" value).
    localparam int PUSH_W = $clog2(DIM_INPUT + 1);
    localparam int POP_W  = (DIM_OUTPUT > 1) ? $clog2(DIM_OUTPUT) : 1;

    localparam logic [PUSH_W-1:0] PUSH_LAST = PUSH_W'(DIM_INPUT - 1);
    localparam logic [PUSH_W-1:0] PUSH_FULL = PUSH_W'(DIM_INPUT);
    localparam logic [POP_W-1:0]  POP_LAST  = POP_W'(DIM_OUTPUT - 1);
    // One extra bit so a DIM_INPUT equal to 2**CNT_W cannot alias to zero.
    localparam logic [CNT_W:0]    START_LVL = (CNT_W + 1)'(DIM_INPUT);

    logic [1:0]        state_q, state_d;
    logic [PUSH_W-1:0] push_cnt_q, push_cnt_d;
    logic [POP_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              fc_in_valid_q;
    logic [DATA_W-1:0] res_q [DIM_OUTPUT];
    logic              capture;
    logic              to_hit;

    assign fifo_rd_en = (state_q == S_PUSH) && !fifo_empty && (push_cnt_q < PUSH_FULL);
    assign capture    = (state_q == S_WAIT_FC) && fc_out_valid;

`ifdef FC_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q;

    // Counter restarts from zero on every WAIT_FC entry because it is held
    // at zero in every other state.
    assign to_cnt_d = (state_q == S_WAIT_FC) ? to_cnt_q + 1'b1 : '0;
    assign to_hit   = (state_q == S_WAIT_FC) && !fc_out_valid && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_hit;
        end
    end

    assign timeout_err = to_err_q;
`else
    // Keeps the watchdog limit referenced in builds without the watchdog.
    localparam int TIMEOUT_CYC_UNUSED = TIMEOUT_CYC;

    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        push_cnt_d  = push_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if ({1'b0, fifo_count} >= START_LVL) begin
                    state_d    = S_PUSH;
                    push_cnt_d = '0;
                end
            end
            S_PUSH: begin
                // Leave on the edge of the last read so the final fc_in_valid
                // beat coincides with the first WAIT_FC cycle.
                if (fifo_rd_en) begin
                    push_cnt_d = push_cnt_q + 1'b1;
                    if (push_cnt_q == PUSH_LAST) begin
                        state_d = S_WAIT_FC;
                    end
                end
            end
            S_WAIT_FC: begin
                if (fc_out_valid) begin
                    state_d   = S_POP;
                    pop_cnt_d = '0;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                if (tx_data_ready) begin
                    if (pop_cnt_q == POP_LAST) begin
                        state_d     = S_IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        pop_cnt_d = pop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            push_cnt_q    <= '0;
            pop_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            fc_in_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            push_cnt_q    <= push_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            // FIFO read data appears one cycle after the strobe.
            fc_in_valid_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIM_OUTPUT; k++) begin
                res_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < DIM_OUTPUT; k++) begin
                res_q[k] <= fc_out_dat[k*DATA_W +: DATA_W];
            end
        end
    end

    assign fc_in_dat     = fifo_dout;
    assign fc_in_valid   = fc_in_valid_q;
    assign tx_data_valid = (state_q == S_POP);
    // pop_cnt only moves on a completed transfer, so tx_data holds during stalls.
    assign tx_data       = (state_q == S_POP) ? res_q[pop_cnt_q] : '0;
    assign busy          = (state_q != S_IDLE);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb/tb_fc_seq_ctrl.sv - self-checking bench for fc_seq_ctrl
`timescale 1ns/1ps

module tb_fc_seq_ctrl;

    localparam int DIM_INPUT   = 96;
    localparam int DIM_OUTPUT  = 8;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 7;
    localparam int TIMEOUT_CYC = 16;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [CNT_W-1:0]             fifo_count = '0;
    logic                         fifo_empty_raw = 1'b1;
    logic                         force_empty = 1'b0;
    logic                         fifo_empty;
    logic                         fifo_rd_en;
    logic [DATA_W-1:0]            fifo_dout = 8'h5A;
    logic [DATA_W-1:0]            fc_in_dat;
    logic                         fc_in_valid;
    logic [DATA_W*DIM_OUTPUT-1:0] fc_out_dat = '0;
    logic                         fc_out_valid = 1'b0;
    logic [DATA_W-1:0]            tx_data;
    logic                         tx_data_valid;
    logic                         tx_data_ready = 1'b0;
    logic                         busy;
    logic [15:0]                  frame_cnt;
`ifdef FC_SEQ_TIMEOUT_EN
    logic                         timeout_err;
`endif

    assign fifo_empty = fifo_empty_raw | force_empty;

    fc_seq_ctrl #(
        .DIM_INPUT   (DIM_INPUT),
        .DIM_OUTPUT  (DIM_OUTPUT),
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .fc_in_dat     (fc_in_dat),
        .fc_in_valid   (fc_in_valid),
        .fc_out_dat    (fc_out_dat),
        .fc_out_valid  (fc_out_valid),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
`ifdef FC_SEQ_TIMEOUT_EN
        .timeout_err   (timeout_err),
`endif
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model and monitors, all sampled on the active edge.
    logic [7:0] fifo_mem [$];
    logic [7:0] beats [$];
    int cyc = 0;
    int rd_n = 0;
    int rd_first = 0;
    int rd_last = 0;
    int underflow = 0;
    int tx_seen = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_mem.size() > 0) fifo_dout <= fifo_mem.pop_front();
            else underflow++;
            if (rd_n == 0) rd_first = cyc;
            rd_last = cyc;
            rd_n++;
        end
        if (fc_in_valid) beats.push_back(fc_in_dat);
        fifo_count     <= CNT_W'(fifo_mem.size());
        fifo_empty_raw <= (fifo_mem.size() == 0);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic        exp_rd;
        logic [15:0] exp_frame;
    } pop_vec_t;

    pop_vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input int base);
        for (int i = 0; i < DIM_INPUT; i++) fifo_mem.push_back(8'(base + i));
    endtask

    task automatic clear_mon();
        beats.delete();
        rd_n = 0;
        tx_seen = 0;
    endtask

    task automatic wait_beats(input string tag);
        for (int i = 0; i < 400 && beats.size() < DIM_INPUT; i++) begin
            @(negedge clk);
            if (tx_data_valid) tx_seen++;
        end
        check({tag, "_beat_count"}, beats.size(), DIM_INPUT);
    endtask

    task automatic check_order(input int base, input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < beats.size() && i < DIM_INPUT; i++) begin
            if (beats[i] !== 8'(base + i)) mism++;
        end
        check({tag, "_data_order_mismatches"}, mism, 0);
    endtask

    task automatic send_result(input logic [7:0] base);
        fc_out_valid = 1'b1;
        for (int k = 0; k < DIM_OUTPUT; k++) fc_out_dat[k*DATA_W +: DATA_W] = 8'(base + k);
        @(negedge clk);
        fc_out_valid = 1'b0;
    endtask

    task automatic pop_all(input logic [7:0] base, input string tag);
        for (int k = 0; k < DIM_OUTPUT; k++) begin
            tx_data_ready = 1'b1;
            check({tag, "_tx_valid"}, tx_data_valid, 1);
            check({tag, "_tx_data"}, tx_data, 8'(base + k));
            @(negedge clk);
        end
        tx_data_ready = 1'b0;
    endtask

    initial begin
        // POP phase of frame 1 with ready toggling 1/0, then the IDLE gap
        // and the immediate restart of the next (already buffered) frame.
        vecs[0]  = '{1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 16'd0};
        vecs[8]  = '{1'b1, 1'b1, 8'h14, 1'b1, 1'b0, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 8'h15, 1'b1, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 1'b1, 8'h15, 1'b1, 1'b0, 16'd0};
        vecs[11] = '{1'b0, 1'b1, 8'h16, 1'b1, 1'b0, 16'd0};
        vecs[12] = '{1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 16'd0};
        vecs[13] = '{1'b0, 1'b1, 8'h17, 1'b1, 1'b0, 16'd0};
        vecs[14] = '{1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 16'd0};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd1};

        // Reset state
        preload(0);
        repeat (3) @(negedge clk);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_fc_in_valid", fc_in_valid, 0);
        check("rst_tx_valid", tx_data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_fc_in_dat", fc_in_dat, 8'h5A);
        rst_n = 1'b1;

        // Frame 1: contiguous push with a stray result pulse mid-PUSH
        for (int i = 0; i < 200 && rd_n < 20; i++) @(negedge clk);
        fc_out_valid = 1'b1;
        fc_out_dat   = {8{8'hEE}};
        @(negedge clk);
        fc_out_valid = 1'b0;
        check("stray_busy", busy, 1);
        check("stray_rd_en", fifo_rd_en, 1);
        check("stray_tx_valid", tx_data_valid, 0);
        wait_beats("f1");
        check_order(0, "f1");
        check("f1_reads", rd_n, DIM_INPUT);
        check("f1_read_span", rd_last - rd_first + 1, DIM_INPUT);
        check("f1_tx_during_push", tx_seen, 0);
        clear_mon();
        preload(100);
        repeat (3) @(negedge clk);
        check("wait_fc_busy", busy, 1);
        check("wait_fc_tx_valid", tx_data_valid, 0);
        send_result(8'h10);
        for (int r = 0; r < 17; r++) begin
            tx_data_ready = vecs[r].ready;
            check($sformatf("pop_row%0d_valid", r), tx_data_valid, vecs[r].exp_valid);
            if (vecs[r].exp_valid) check($sformatf("pop_row%0d_data", r), tx_data, vecs[r].exp_data);
            check($sformatf("pop_row%0d_busy", r), busy, vecs[r].exp_busy);
            check($sformatf("pop_row%0d_rd_en", r), fifo_rd_en, vecs[r].exp_rd);
            check($sformatf("pop_row%0d_frame", r), frame_cnt, vecs[r].exp_frame);
            @(negedge clk);
        end
        tx_data_ready = 1'b0;

        // Frame 2: FIFO runs empty for 5 cycles after 40 reads
        for (int i = 0; i < 200 && rd_n < 40; i++) @(negedge clk);
        check("f2_reads_before_stall", rd_n, 40);
        force_empty = 1'b1;
        @(negedge clk);
        check("f2_stall_rd_en", fifo_rd_en, 0);
        check("f2_stall_busy", busy, 1);
        repeat (4) @(negedge clk);
        force_empty = 1'b0;
        wait_beats("f2");
        check_order(100, "f2");
        check("f2_reads", rd_n, DIM_INPUT);
        check("f2_read_span", rd_last - rd_first + 1, DIM_INPUT + 5);
        send_result(8'h20);
        pop_all(8'h20, "f2");
        check("f2_frame_cnt", frame_cnt, 2);
        check("f2_idle_busy", busy, 0);
        check("f2_idle_tx_valid", tx_data_valid, 0);

        // Frame 3: reset asserted during POP with pop_cnt at 3
        clear_mon();
        preload(50);
        wait_beats("f3");
        check_order(50, "f3");
        send_result(8'hA0);
        for (int k = 0; k < 3; k++) begin
            tx_data_ready = 1'b1;
            @(negedge clk);
        end
        tx_data_ready = 1'b0;
        check("f3_pop3_data", tx_data, 8'hA3);
        check("f3_pop3_valid", tx_data_valid, 1);
        rst_n = 1'b0;
        #1;
        check("f3_rst_tx_valid", tx_data_valid, 0);
        check("f3_rst_busy", busy, 0);
        check("f3_rst_frame_cnt", frame_cnt, 0);
        check("f3_rst_tx_data", tx_data, 0);
        check("f3_rst_rd_en", fifo_rd_en, 0);
        check("f3_rst_fc_in_valid", fc_in_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame 4: normal frame after the mid-frame reset
        clear_mon();
        preload(200);
        wait_beats("f4");
        check_order(200, "f4");
        send_result(8'h30);
        pop_all(8'h30, "f4");
        check("f4_frame_cnt", frame_cnt, 1);
        check("f4_idle_busy", busy, 0);

`ifdef FC_SEQ_TIMEOUT_EN
        // Watchdog: no result pulse, timeout 16 cycles after WAIT_FC entry
        clear_mon();
        preload(7);
        wait_beats("to");
        for (int i = 0; i < 64 && timeout_err !== 1'b1; i++) @(negedge clk);
        check("to_pulse", timeout_err, 1);
        check("to_cycle", cyc, rd_last + 1 + TIMEOUT_CYC);
        check("to_busy", busy, 0);
        check("to_frame_cnt", frame_cnt, 1);
        check("to_tx_valid", tx_data_valid, 0);
        @(negedge clk);
        check("to_pulse_end", timeout_err, 0);
`endif

        check("fifo_underflow", underflow, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_seq_ctrl.md
FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 SHALL have parameter DIM_INPUT, 96, input vector length in bytes.
REQ-002 SHALL have parameter DIM_OUTPUT, 8, output neuron count.
REQ-003 SHALL have parameter DATA_W, 8, byte/neuron width.
REQ-004 SHALL have parameter CNT_W, 7, FIFO data_count width.
REQ-005 SHALL have parameter TIMEOUT_CYC, 4096, FC result watchdog limit in cycles.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 fifo_count  in  CNT_W  rx FIFO occupancy.
REQ-009 fifo_empty  in  1  rx FIFO empty.
REQ-010 fifo_rd_en  out  1  FIFO read strobe; data on fifo_dout one cycle later.
REQ-011 fifo_dout  in  DATA_W  FIFO read data.
REQ-012 fc_in_dat  out  DATA_W  byte to FC layer.
REQ-013 fc_in_valid  out  1  fc_in_dat qualifier.
REQ-014 fc_out_dat  in  DATA_W*DIM_OUTPUT  flattened FC results, neuron k at bits [k*DATA_W +: DATA_W].
REQ-015 fc_out_valid  in  1  one-cycle result pulse.
REQ-016 tx_data  out  DATA_W  byte to UART transmitter.
REQ-017 tx_data_valid  out  1  tx_data offered.
REQ-018 tx_data_ready  in  1  UART accepts byte when valid&ready.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-021 FSM SHALL have states IDLE, PUSH, WAIT_FC, POP.
REQ-022 IDLE->PUSH SHALL occur when fifo_count >= DIM_INPUT; push_cnt cleared.
REQ-023 In PUSH, fifo_rd_en = ~fifo_empty & (push_cnt < DIM_INPUT), combinational; push_cnt increments per read.
REQ-024 fifo_empty mid-PUSH SHALL stall reads without leaving PUSH; reading resumes when not empty.
REQ-025 fc_in_valid SHALL be fifo_rd_en delayed one cycle; fc_in_dat = fifo_dout; exactly DIM_INPUT valid beats per frame.
REQ-026 PUSH->WAIT_FC SHALL occur the cycle after the DIM_INPUT-th read (last fc_in_valid beat).
REQ-027 In WAIT_FC, fc_out_valid SHALL capture all fc_out_dat into an internal buffer and move to POP with pop_cnt=0.
REQ-028 fc_out_valid in any state other than WAIT_FC SHALL be ignored.
REQ-029 In POP, tx_data_valid=1, tx_data=buffer[pop_cnt]; on valid&ready pop_cnt increments.
REQ-030 tx_data SHALL stay stable while valid&~ready.
REQ-031 Transfer with pop_cnt==DIM_OUTPUT-1 SHALL return to IDLE and increment frame_cnt same edge.
REQ-032 Returning to IDLE with fifo_count >= DIM_INPUT SHALL start next PUSH on the following cycle (one IDLE cycle minimum).
REQ-033 Latency fc_out_valid -> first tx_data_valid SHALL be 1 cycle.

Reset
REQ-034 Reset SHALL force IDLE, push_cnt=0, pop_cnt=0, buffer=0, frame_cnt=0.
REQ-035 Outputs under reset: fifo_rd_en=0, fc_in_valid=0, tx_data_valid=0, busy=0, tx_data=0, fc_in_dat=fifo_dout.
REQ-036 Reset mid-frame SHALL abandon the frame; unread FIFO bytes are not discarded by this block.

Configuration
REQ-037 Macro FC_SEQ_TIMEOUT_EN defined: WAIT_FC counts cycles; reaching TIMEOUT_CYC without fc_out_valid returns to IDLE, frame_cnt unchanged, output port timeout_err pulses 1 cycle.
REQ-038 FC_SEQ_TIMEOUT_EN undefined: no counter, no timeout_err port, WAIT_FC waits indefinitely.

Verification
REQ-039 96 bytes 0..95 preloaded, fifo_count=96 -> 96 fc_in_valid beats carrying 0..95 in order, fifo_rd_en high 96 cycles contiguous.
REQ-040 fifo_empty forced high 5 cycles after 40 reads -> reads pause 5 cycles, total beats still 96, data order intact.
REQ-041 fc_out_valid with neurons 0x10..0x17, tx_data_ready toggling 1/0 -> tx bytes 0x10..0x17 in order, data stable during stalls, frame_cnt 0->1.
REQ-042 Stray fc_out_valid during PUSH -> ignored, no tx_data_valid, FSM stays PUSH.
REQ-043 rst_n low during POP at pop_cnt=3 -> immediately tx_data_valid=0, busy=0, frame_cnt=0; next frame completes normally.
REQ-044 FC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, no fc_out_valid -> timeout_err pulse 16 cycles after WAIT_FC entry, state IDLE, frame_cnt unchanged.
